// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/commit controller wrapped around a combinational ALU.
// Accepts one decoded integer op at a time, holds the ALU inputs stable for
// the op's execute window, samples the ALU results on the final execute cycle
// and then either commits them (register file, ICC, Y) or raises a held trap.
module alu_issue_ctrl #(
  parameter int          MULDIV_CYCLES = 4,
  parameter logic [7:0]  TT_DIV_ZERO   = 8'h2A,
  parameter logic [7:0]  TT_TAG_OVF    = 8'h0A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [5:0]  issue_opcode,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  input  logic [4:0]  issue_rd_addr,
  input  logic        flush,
  output logic [5:0]  alu_opcode,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [3:0]  alu_icc_in,
  output logic [31:0] alu_y_in,
  input  logic [31:0] alu_rd,
  input  logic [3:0]  alu_icc_out,
  input  logic [31:0] alu_y_out,
  input  logic        alu_div_zero,
  input  logic        alu_tag_ovf,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [3:0]  icc,
  output logic [31:0] y,
  output logic        trap_valid,
  output logic [7:0]  trap_type,
  input  logic        trap_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_TRAP = 2'd3;

  localparam logic [5:0] OP_NOP = 6'h3F;

  // The counter only has to hold MULDIV_CYCLES-1; keep at least one bit.
  localparam int                CNT_W      = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MULDIV = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  // Multiply/divide ops (plain and cc forms) occupy the long execute window.
  function automatic logic is_muldiv(input logic [5:0] op);
    case (op)
      6'h0A, 6'h0B, 6'h0E, 6'h0F,
      6'h1A, 6'h1B, 6'h1E, 6'h1F: is_muldiv = 1'b1;
      default:                    is_muldiv = 1'b0;
    endcase
  endfunction

  // Condition-code setting ops: every op3 with bit 4 set, plus the tagged
  // add/sub family and MULScc (20..24).
  function automatic logic is_cc(input logic [5:0] op);
    is_cc = op[4] || ((op >= 6'h20) && (op <= 6'h24));
  endfunction

  // Ops whose Y result is architecturally visible: UMUL/SMUL, their cc
  // forms, and MULScc.
  function automatic logic writes_y(input logic [5:0] op);
    case (op)
      6'h0A, 6'h0B, 6'h1A, 6'h1B, 6'h24: writes_y = 1'b1;
      default:                           writes_y = 1'b0;
    endcase
  endfunction

  logic [1:0]       state_q,       state_d;
  logic             issue_ready_q, issue_ready_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic [5:0]       op_q,          op_d;
  logic [31:0]      rs1_q,         rs1_d;
  logic [31:0]      rs2_q,         rs2_d;
  logic [4:0]       rd_addr_q,     rd_addr_d;
  logic             wb_valid_q,    wb_valid_d;
  logic [4:0]       wb_addr_q,     wb_addr_d;
  logic [31:0]      wb_data_q,     wb_data_d;
  logic [3:0]       icc_q,         icc_d;
  logic [31:0]      y_q,           y_d;
  logic             trap_valid_q,  trap_valid_d;
  logic [7:0]       trap_type_q,   trap_type_d;

  logic issue_fire;

  // A flush in IDLE must block the handshake in the same cycle, so the
  // registered ready is gated by flush on its way out.
  assign issue_ready = issue_ready_q & ~flush;
  assign issue_fire  = issue_valid & issue_ready;

  assign alu_opcode  = op_q;
  assign alu_rs1     = rs1_q;
  assign alu_rs2     = rs2_q;
  assign alu_icc_in  = icc_q;
  assign alu_y_in    = y_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign icc         = icc_q;
  assign y           = y_q;
  assign trap_valid  = trap_valid_q;
  assign trap_type   = trap_type_q;

  // Next-state logic: handshake capture, execute countdown, result sampling
  // into the commit registers (or the trap request), and flush/ack handling.
  // The commit registers (wb_*, icc, y) are loaded on the edge that enters
  // WB, so the write strobe and the new ICC/Y are visible together for the
  // single WB cycle; a flush arriving during WB therefore cannot undo it.
  always_comb begin
    state_d       = state_q;
    issue_ready_d = issue_ready_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_addr_d     = rd_addr_q;
    wb_valid_d    = 1'b0;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    icc_d         = icc_q;
    y_d           = y_q;
    trap_valid_d  = trap_valid_q;
    trap_type_d   = trap_type_q;

    case (state_q)
      S_IDLE: begin
        if (issue_fire) begin
          state_d       = S_EXEC;
          issue_ready_d = 1'b0;
          op_d          = issue_opcode;
          rs1_d         = issue_rs1;
          rs2_d         = issue_rs2;
          rd_addr_d     = issue_rd_addr;
          cnt_d         = is_muldiv(issue_opcode) ? CNT_MULDIV : '0;
        end else begin
          issue_ready_d = 1'b1;
        end
      end

      S_EXEC: begin
        if (flush) begin
          state_d       = S_IDLE;
          issue_ready_d = 1'b1;
          op_d          = OP_NOP;
        end else if (cnt_q == '0) begin
          op_d = OP_NOP;
          if (alu_div_zero) begin
            state_d      = S_TRAP;
            trap_valid_d = 1'b1;
            trap_type_d  = TT_DIV_ZERO;
          end else if (alu_tag_ovf) begin
            state_d      = S_TRAP;
            trap_valid_d = 1'b1;
            trap_type_d  = TT_TAG_OVF;
          end else begin
            state_d    = S_WB;
            wb_valid_d = (rd_addr_q != 5'd0);
            wb_addr_d  = rd_addr_q;
            wb_data_d  = alu_rd;
            if (is_cc(op_q)) begin
              icc_d = alu_icc_out;
            end
            if (writes_y(op_q)) begin
              y_d = alu_y_out;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_WB: begin
        state_d       = S_IDLE;
        issue_ready_d = 1'b1;
      end

      S_TRAP: begin
        if (flush || trap_ack) begin
          state_d       = S_IDLE;
          issue_ready_d = 1'b1;
          trap_valid_d  = 1'b0;
        end
      end

      default: begin
        state_d       = S_IDLE;
        issue_ready_d = 1'b0;
        op_d          = OP_NOP;
      end
    endcase
  end

  // State registers; reset drops any in-flight op and parks the ALU on no-op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      issue_ready_q <= 1'b0;
      cnt_q         <= '0;
      op_q          <= OP_NOP;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_addr_q     <= '0;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      icc_q         <= '0;
      y_q           <= '0;
      trap_valid_q  <= 1'b0;
      trap_type_q   <= '0;
    end else begin
      state_q       <= state_d;
      issue_ready_q <= issue_ready_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_addr_q     <= rd_addr_d;
      wb_valid_q    <= wb_valid_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      icc_q         <= icc_d;
      y_q           <= y_d;
      trap_valid_q  <= trap_valid_d;
      trap_type_q   <= trap_type_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: drives alu_issue_ctrl with a small behavioural ALU,
// runs a table of ops, then hand-written flush/reset/trap sequences.
// Register-file writes are checked through an expected-write queue.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_opcode;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic [4:0]  issue_rd_addr;
  logic        flush;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [3:0]  alu_icc_in;
  logic [31:0] alu_y_in;
  logic [31:0] alu_rd;
  logic [3:0]  alu_icc_out;
  logic [31:0] alu_y_out;
  logic        alu_div_zero;
  logic        alu_tag_ovf;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  icc;
  logic [31:0] y;
  logic        trap_valid;
  logic [7:0]  trap_type;
  logic        trap_ack;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          lat;
    bit          trap;
    logic [7:0]  tt;
    logic [31:0] data;
    bit          upd_icc;
    logic [3:0]  icc;
    bit          upd_y;
    logic [31:0] y;
    bit          ftag;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t     exp_q[$];
  vec_t        vecs[13];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  model_icc;
  logic [31:0] model_y;
  logic        force_tag;

  logic [32:0] m_sum;
  logic [32:0] m_diff;
  logic [63:0] m_prod;
  logic        m_tag;
  logic        m_add_v;
  logic        m_sub_v;

  alu_issue_ctrl #(
    .MULDIV_CYCLES(4),
    .TT_DIV_ZERO  (8'h2A),
    .TT_TAG_OVF   (8'h0A)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_opcode (issue_opcode),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_rd_addr(issue_rd_addr),
    .flush        (flush),
    .alu_opcode   (alu_opcode),
    .alu_rs1      (alu_rs1),
    .alu_rs2      (alu_rs2),
    .alu_icc_in   (alu_icc_in),
    .alu_y_in     (alu_y_in),
    .alu_rd       (alu_rd),
    .alu_icc_out  (alu_icc_out),
    .alu_y_out    (alu_y_out),
    .alu_div_zero (alu_div_zero),
    .alu_tag_ovf  (alu_tag_ovf),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .icc          (icc),
    .y            (y),
    .trap_valid   (trap_valid),
    .trap_type    (trap_type),
    .trap_ack     (trap_ack)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational ALU. Non-cc ops drive a
  // distinctive ICC/Y pattern so that an unwanted commit is visible.
  always_comb begin
    m_sum        = {1'b0, alu_rs1} + {1'b0, alu_rs2};
    m_diff       = {1'b0, alu_rs1} - {1'b0, alu_rs2};
    m_prod       = {32'd0, alu_rs1} * {32'd0, alu_rs2};
    m_tag        = (alu_rs1[1:0] != 2'b00) || (alu_rs2[1:0] != 2'b00);
    m_add_v      = (alu_rs1[31] == alu_rs2[31]) && (m_sum[31] != alu_rs1[31]);
    m_sub_v      = (alu_rs1[31] != alu_rs2[31]) && (m_diff[31] != alu_rs1[31]);
    alu_rd       = 32'd0;
    alu_icc_out  = 4'b0101;
    alu_y_out    = 32'hA5A5_A5A5;
    alu_div_zero = 1'b0;
    alu_tag_ovf  = force_tag;
    case (alu_opcode)
      6'h00: alu_rd = m_sum[31:0];
      6'h10: begin
        alu_rd      = m_sum[31:0];
        alu_icc_out = {m_sum[31], m_sum[31:0] == 32'd0, m_add_v, m_sum[32]};
      end
      6'h04: alu_rd = m_diff[31:0];
      6'h14: begin
        alu_rd      = m_diff[31:0];
        alu_icc_out = {m_diff[31], m_diff[31:0] == 32'd0, m_sub_v, m_diff[32]};
      end
      6'h0A: begin
        alu_rd    = m_prod[31:0];
        alu_y_out = m_prod[63:32];
      end
      6'h1A: begin
        alu_rd      = m_prod[31:0];
        alu_y_out   = m_prod[63:32];
        alu_icc_out = {m_prod[31], m_prod[31:0] == 32'd0, 2'b00};
      end
      6'h0E: begin
        if (alu_rs2 == 32'd0) alu_div_zero = 1'b1;
        else                  alu_rd = alu_rs1 / alu_rs2;
      end
      6'h0F: begin
        if (alu_rs2 == 32'd0) alu_div_zero = 1'b1;
        else                  alu_rd = $signed(alu_rs1) / $signed(alu_rs2);
      end
      6'h20: begin
        alu_rd      = m_sum[31:0];
        alu_icc_out = {m_sum[31], m_sum[31:0] == 32'd0, m_add_v | m_tag, m_sum[32]};
      end
      6'h22: begin
        alu_rd      = m_sum[31:0];
        alu_icc_out = {m_sum[31], m_sum[31:0] == 32'd0, m_add_v | m_tag, m_sum[32]};
        alu_tag_ovf = force_tag | m_add_v | m_tag;
      end
      6'h24: begin
        alu_rd      = m_sum[31:0];
        alu_y_out   = {alu_rs1[0], alu_y_in[31:1]};
        alu_icc_out = {m_sum[31], m_sum[31:0] == 32'd0, m_add_v, m_sum[32]};
      end
      default: ;
    endcase
  end

  function automatic vec_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input int lat, input bit trap,
                              input logic [7:0] tt, input logic [31:0] data, input bit upd_icc,
                              input logic [3:0] icc_v, input bit upd_y, input logic [31:0] y_v,
                              input bit ftag);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.rd = rd; v.lat = lat; v.trap = trap; v.tt = tt;
    v.data = data; v.upd_icc = upd_icc; v.icc = icc_v; v.upd_y = upd_y; v.y = y_v;
    v.ftag = ftag;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait (bounded) for ready, then present one op for a single handshake edge.
  task automatic applyStimulus(input vec_t v);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!issue_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ready_wait", {31'd0, issue_ready}, 32'd1);
    issue_valid   = 1'b1;
    issue_opcode  = v.op;
    issue_rs1     = v.a;
    issue_rs2     = v.b;
    issue_rd_addr = v.rd;
    force_tag     = v.ftag;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  // One table entry: execute window, commit or trap, then return to IDLE.
  task automatic runVector(input vec_t v);
    if (!v.trap && v.rd != 5'd0) exp_q.push_back('{addr: v.rd, data: v.data});
    applyStimulus(v);
    for (int n = 1; n <= v.lat; n++) begin
      @(negedge clk);
      checkOutput("exec_opcode", {26'd0, alu_opcode}, {26'd0, v.op});
      checkOutput("exec_no_wb", {31'd0, wb_valid}, 32'd0);
      if (n == 1 || n == v.lat) begin
        checkOutput("exec_rs1", alu_rs1, v.a);
        checkOutput("exec_rs2", alu_rs2, v.b);
        checkOutput("exec_icc_in", {28'd0, alu_icc_in}, {28'd0, model_icc});
        checkOutput("exec_y_in", alu_y_in, model_y);
      end
    end
    @(negedge clk);
    if (v.trap) begin
      checkOutput("trap_valid", {31'd0, trap_valid}, 32'd1);
      checkOutput("trap_type", {24'd0, trap_type}, {24'd0, v.tt});
      checkOutput("trap_no_wb", {31'd0, wb_valid}, 32'd0);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        checkOutput("trap_held", {31'd0, trap_valid}, 32'd1);
        checkOutput("trap_not_ready", {31'd0, issue_ready}, 32'd0);
      end
      trap_ack = 1'b1;
      @(posedge clk);
      #1;
      trap_ack = 1'b0;
      @(negedge clk);
      checkOutput("trap_cleared", {31'd0, trap_valid}, 32'd0);
    end else begin
      checkOutput("wb_strobe", {31'd0, wb_valid}, {31'd0, v.rd != 5'd0});
      checkOutput("wb_alu_nop", {26'd0, alu_opcode}, 32'h3F);
      if (v.upd_icc) model_icc = v.icc;
      if (v.upd_y)   model_y   = v.y;
      @(negedge clk);
      checkOutput("wb_single", {31'd0, wb_valid}, 32'd0);
    end
    checkOutput("ready_after", {31'd0, issue_ready}, 32'd1);
    checkOutput("icc_after", {28'd0, icc}, {28'd0, model_icc});
    checkOutput("y_after", y, model_y);
    force_tag = 1'b0;
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_wb: got addr %0d data %h, expected no write", wb_addr, wb_data);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        checkOutput("sb_wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
        checkOutput("sb_wb_data", wb_data, e.data);
      end
    end
  end

  // Absolute time limit so a stuck handshake still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t hv;
    issue_valid = 1'b0; issue_opcode = 6'h00; issue_rs1 = 32'd0; issue_rs2 = 32'd0;
    issue_rd_addr = 5'd0; flush = 1'b0; trap_ack = 1'b0; force_tag = 1'b0;
    model_icc = 4'd0; model_y = 32'd0;

    //            op     a             b      rd  lat trap tt     data          uicc icc     uy y             ftag
    vecs[0]  = mk(6'h00, 32'd5,        32'd7,  3,  1, 0, 8'h00, 32'd12,       0, 4'b0000, 0, 32'd0,        0);
    vecs[1]  = mk(6'h10, 32'h7FFFFFFF, 32'd1,  0,  1, 0, 8'h00, 32'h80000000, 1, 4'b1010, 0, 32'd0,        0);
    vecs[2]  = mk(6'h0A, 32'hFFFFFFFF, 32'd2,  4,  4, 0, 8'h00, 32'hFFFFFFFE, 0, 4'b0000, 1, 32'd1,        0);
    vecs[3]  = mk(6'h14, 32'd5,        32'd5,  7,  1, 0, 8'h00, 32'd0,        1, 4'b0100, 0, 32'd0,        0);
    vecs[4]  = mk(6'h1A, 32'h80000001, 32'd4,  9,  4, 0, 8'h00, 32'd4,        1, 4'b0000, 1, 32'd2,        0);
    vecs[5]  = mk(6'h04, 32'd3,        32'd10, 31, 1, 0, 8'h00, 32'hFFFFFFF9, 0, 4'b0000, 0, 32'd0,        0);
    vecs[6]  = mk(6'h20, 32'd1,        32'd4,  2,  1, 0, 8'h00, 32'd5,        1, 4'b0010, 0, 32'd0,        0);
    vecs[7]  = mk(6'h0E, 32'd100,      32'd0,  8,  4, 1, 8'h2A, 32'd0,        0, 4'b0000, 0, 32'd0,        0);
    vecs[8]  = mk(6'h22, 32'd1,        32'd4,  11, 1, 1, 8'h0A, 32'd0,        0, 4'b0000, 0, 32'd0,        0);
    vecs[9]  = mk(6'h0E, 32'd100,      32'd7,  5,  4, 0, 8'h00, 32'd14,       0, 4'b0000, 0, 32'd0,        0);
    vecs[10] = mk(6'h0E, 32'd100,      32'd0,  8,  4, 1, 8'h2A, 32'd0,        0, 4'b0000, 0, 32'd0,        1);
    vecs[11] = mk(6'h0F, 32'hFFFFFFEC, 32'd4,  6,  4, 0, 8'h00, 32'hFFFFFFFB, 0, 4'b0000, 0, 32'd0,        0);
    vecs[12] = mk(6'h24, 32'd3,        32'd4,  10, 1, 0, 8'h00, 32'd7,        1, 4'b0000, 1, 32'h80000001, 0);

    // Reset values, then ready in the first cycle after release.
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {31'd0, issue_ready}, 32'd0);
    checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_icc", {28'd0, icc}, 32'd0);
    checkOutput("rst_y", y, 32'd0);
    checkOutput("rst_trap_valid", {31'd0, trap_valid}, 32'd0);
    checkOutput("rst_trap_type", {24'd0, trap_type}, 32'd0);
    checkOutput("rst_alu_opcode", {26'd0, alu_opcode}, 32'h3F);
    checkOutput("rst_alu_rs1", alu_rs1, 32'd0);
    checkOutput("rst_alu_rs2", alu_rs2, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'd0, issue_ready}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      runVector(vecs[i]);
    end

    // Flush on the second EXEC edge of a multiply: nothing commits.
    $display("[TB] flush during multiply");
    hv = mk(6'h0A, 32'hFFFFFFFF, 32'd2, 5'd4, 4, 0, 8'h00, 32'd0, 0, 4'd0, 0, 32'd0, 0);
    applyStimulus(hv);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_mul_ready", {31'd0, issue_ready}, 32'd1);
    checkOutput("flush_mul_nop", {26'd0, alu_opcode}, 32'h3F);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("flush_mul_no_wb", {31'd0, wb_valid}, 32'd0);
    end
    checkOutput("flush_mul_y", y, model_y);

    // Flush on the single EXEC cycle of ADDcc beats the result sample.
    $display("[TB] flush beats final sample");
    hv = mk(6'h10, 32'h7FFFFFFF, 32'd1, 5'd12, 1, 0, 8'h00, 32'd0, 0, 4'd0, 0, 32'd0, 0);
    applyStimulus(hv);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_fin_no_wb", {31'd0, wb_valid}, 32'd0);
    checkOutput("flush_fin_ready", {31'd0, issue_ready}, 32'd1);
    @(negedge clk);
    checkOutput("flush_fin_icc", {28'd0, icc}, {28'd0, model_icc});

    // Flush alone clears a pending trap.
    $display("[TB] flush in trap");
    hv = mk(6'h0E, 32'd9, 32'd0, 5'd1, 4, 0, 8'h00, 32'd0, 0, 4'd0, 0, 32'd0, 0);
    applyStimulus(hv);
    repeat (5) @(negedge clk);
    checkOutput("flush_trap_set", {31'd0, trap_valid}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_trap_clr", {31'd0, trap_valid}, 32'd0);
    checkOutput("flush_trap_ready", {31'd0, issue_ready}, 32'd1);

    // Flush in IDLE suppresses the handshake.
    $display("[TB] flush in idle");
    issue_valid = 1'b1; issue_opcode = 6'h00; issue_rs1 = 32'd1; issue_rs2 = 32'd2;
    issue_rd_addr = 5'd13; flush = 1'b1;
    #1;
    checkOutput("flush_idle_ready", {31'd0, issue_ready}, 32'd0);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_idle_nop", {26'd0, alu_opcode}, 32'h3F);
    checkOutput("flush_idle_ready2", {31'd0, issue_ready}, 32'd1);
    repeat (3) @(negedge clk);

    // Flush during WB: the commit still lands.
    $display("[TB] flush in writeback");
    exp_q.push_back('{addr: 5'd14, data: 32'd42});
    hv = mk(6'h00, 32'd20, 32'd22, 5'd14, 1, 0, 8'h00, 32'd42, 0, 4'd0, 0, 32'd0, 0);
    applyStimulus(hv);
    @(negedge clk);
    @(negedge clk);
    checkOutput("flush_wb_strobe", {31'd0, wb_valid}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_wb_ready", {31'd0, issue_ready}, 32'd1);

    // Reset pulsed in the middle of a multiply.
    $display("[TB] reset mid-operation");
    hv = mk(6'h0A, 32'hFFFFFFFF, 32'd2, 5'd4, 4, 0, 8'h00, 32'd0, 0, 4'd0, 0, 32'd0, 0);
    applyStimulus(hv);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_icc = 4'd0;
    model_y   = 32'd0;
    checkOutput("mid_rst_ready", {31'd0, issue_ready}, 32'd0);
    checkOutput("mid_rst_nop", {26'd0, alu_opcode}, 32'h3F);
    checkOutput("mid_rst_rs1", alu_rs1, 32'd0);
    checkOutput("mid_rst_wb", {31'd0, wb_valid}, 32'd0);
    checkOutput("mid_rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    checkOutput("mid_rst_wb_data", wb_data, 32'd0);
    checkOutput("mid_rst_y", y, 32'd0);
    checkOutput("mid_rst_icc", {28'd0, icc}, 32'd0);
    checkOutput("mid_rst_trap", {31'd0, trap_valid}, 32'd0);
    checkOutput("mid_rst_tt", {24'd0, trap_type}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_ready_up", {31'd0, issue_ready}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("mid_rst_no_wb", {31'd0, wb_valid}, 32'd0);
    end

    // Normal operation resumes after the reset.
    runVector(vecs[0]);

    checkOutput("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
